debug_dump_serializer: RTL

DEBUG_DUMP_SERIALIZER -- requirements
Module: debug_dump_serializer

---
 rtl/debug_dump_serializer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/debug_dump_serializer.sv
// debug_dump_serializer: streams a padded snapshot, then an inclusive memory range, as UART bytes.
// Latency: each byte waits for two consecutive i_tx_done samples, then gets a one-cycle o_tx_start pulse.
// Backpressure: i_tx_done low stalls in WAIT_TX. Define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module debug_dump_serializer #(
  parameter int UART_BITS = 8,
  parameter int SNAP_BITS = 1024,
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [SNAP_BITS-1:0] i_snapshot,
  input  logic [ADDR_BITS-1:0] i_first_addr,
  input  logic [ADDR_BITS-1:0] i_last_addr,
  input  logic [WORD_BITS-1:0] i_mem_data,
  input  logic                 i_tx_done,
  output logic                 o_mem_rd_en,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic                 o_tx_start,
  output logic [UART_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3:0]           o_state
);

  localparam int SNAP_BYTES = (SNAP_BITS + UART_BITS - 1) / UART_BITS;
  localparam int PAD_BITS   = SNAP_BYTES * UART_BITS;
  localparam int WORD_BYTES = WORD_BITS / UART_BITS;
  localparam int CNT_MAX    = (SNAP_BYTES > WORD_BYTES) ? SNAP_BYTES : WORD_BYTES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SNAP_LAST = CNT_W'(SNAP_BYTES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LOAD_BYTE   = 4'd1,
    WAIT_TX     = 4'd2,
    SEND        = 4'd3,
    MEM_REQ     = 4'd4,
    MEM_CAPTURE = 4'd5,
    CHECKSUM    = 4'd6,
    FINISH      = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_SNAP = 2'd0,
    PH_MEM  = 2'd1,
    PH_CSUM = 2'd2
  } phase_t;

  state_t               state_q;
  phase_t               phase_q;
  logic [PAD_BITS-1:0]  snap_q;
  logic [PAD_BITS-1:0]  snap_d;
  logic [WORD_BITS-1:0] word_q;
  logic [UART_BITS-1:0] byte_q;
  logic [UART_BITS-1:0] xor_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] last_q;
  logic                 empty_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rdy_q;

  logic                 tx_start_q;
  logic [UART_BITS-1:0] tx_data_q;
  logic                 mem_rd_en_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic                 busy_q;
  logic                 done_q;

  // Where the dump goes once the last data byte has left.
  state_t end_state;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  assign end_state = CHECKSUM;
`else
  assign end_state = FINISH;
`endif

  // Snapshot left-aligned, the unused low-order bits of the last byte filled with 1s.
  always_comb begin
    snap_d = '1;
    snap_d[PAD_BITS-1 -: SNAP_BITS] = i_snapshot;
  end

  // Main sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_SNAP;
      snap_q      <= '0;
      word_q      <= '0;
      byte_q      <= '0;
      xor_q       <= '0;
      addr_q      <= '0;
      last_q      <= '0;
      empty_q     <= 1'b0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            snap_q  <= snap_d;
            addr_q  <= i_first_addr;
            last_q  <= i_last_addr;
            empty_q <= (i_last_addr < i_first_addr);
            phase_q <= PH_SNAP;
            cnt_q   <= '0;
            xor_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD_BYTE;
          end
        end

        LOAD_BYTE: begin
          case (phase_q)
            PH_SNAP: begin
              byte_q <= snap_q[PAD_BITS-1 -: UART_BITS];
              snap_q <= snap_q << UART_BITS;
            end
            PH_MEM: begin
              byte_q <= MSB_FIRST ? word_q[WORD_BITS-1 -: UART_BITS] : word_q[UART_BITS-1:0];
              word_q <= MSB_FIRST ? (word_q << UART_BITS) : (word_q >> UART_BITS);
            end
            default: byte_q <= xor_q;
          endcase
          rdy_q   <= 1'b0;
          state_q <= WAIT_TX;
        end

        WAIT_TX: begin
          // Two consecutive idle samples guard against a transmitter that is only momentarily idle.
          if (i_tx_done) begin
            if (rdy_q) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= byte_q;
              state_q    <= SEND;
            end else begin
              rdy_q <= 1'b1;
            end
          end else begin
            rdy_q <= 1'b0;
          end
        end

        SEND: begin
          tx_start_q <= 1'b0;
          tx_data_q  <= '0;
          xor_q      <= xor_q ^ byte_q;
          cnt_q      <= cnt_q + CNT_W'(1);
          case (phase_q)
            PH_SNAP: begin
              if (cnt_q == SNAP_LAST) begin
                cnt_q <= '0;
                if (empty_q) begin
                  state_q <= end_state;
                  done_q  <= (end_state == FINISH);
                end else begin
                  phase_q     <= PH_MEM;
                  mem_rd_en_q <= 1'b1;
                  mem_addr_q  <= addr_q;
                  state_q     <= MEM_REQ;
                end
              end else begin
                state_q <= LOAD_BYTE;
              end
            end
            PH_MEM: begin
              if (cnt_q == WORD_LAST) begin
                cnt_q <= '0;
                // Compare before incrementing so a range ending at the top address never wraps.
                if (addr_q == last_q) begin
                  state_q <= end_state;
                  done_q  <= (end_state == FINISH);
                end else begin
                  addr_q      <= addr_q + ADDR_BITS'(1);
                  mem_rd_en_q <= 1'b1;
                  mem_addr_q  <= addr_q + ADDR_BITS'(1);
                  state_q     <= MEM_REQ;
                end
              end else begin
                state_q <= LOAD_BYTE;
              end
            end
            default: begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          endcase
        end

        MEM_REQ: begin
          state_q <= MEM_CAPTURE;
        end

        MEM_CAPTURE: begin
          word_q      <= i_mem_data;
          mem_rd_en_q <= 1'b0;
          mem_addr_q  <= '0;
          cnt_q       <= '0;
          state_q     <= LOAD_BYTE;
        end

        CHECKSUM: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
          phase_q <= PH_CSUM;
          state_q <= LOAD_BYTE;
`else
          state_q <= FINISH;
          done_q  <= 1'b1;
`endif
        end

        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mem_rd_en = mem_rd_en_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_state     = state_q;

endmodule
